// File: rtl/factocore_reg_writer.sv
// FactoCore slave write path: register bank, engine start/clear strobes,
// result capture on completion and the done interrupt.
module factocore_reg_writer #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              S_sel,
  input  logic              S_wr,
  input  logic [ADDR_W-1:0] S_address,
  input  logic [DATA_W-1:0] S_din,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result_h,
  input  logic [DATA_W-1:0] core_result_l,
  output logic              start_pulse,
  output logic              clear_pulse,
  output logic              busy,
  output logic              interrupt,
  output logic [DATA_W-1:0] reg_opstart,
  output logic [DATA_W-1:0] reg_opclear,
  output logic [DATA_W-1:0] reg_opdone,
  output logic [DATA_W-1:0] reg_intrEn,
  output logic [DATA_W-1:0] reg_operand,
  output logic [DATA_W-1:0] reg_result_h,
  output logic [DATA_W-1:0] reg_result_l
);

  localparam int unsigned SEL_W = 5;

  localparam logic [SEL_W-1:0] SEL_OPSTART = 5'b00000;
  localparam logic [SEL_W-1:0] SEL_OPCLEAR = 5'b00001;
  localparam logic [SEL_W-1:0] SEL_INTREN  = 5'b00011;
  localparam logic [SEL_W-1:0] SEL_OPERAND = 5'b00100;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic             wr_en;
  logic [SEL_W-1:0] sel;
  logic             clr_hit;
  logic             unused_addr;

  assign wr_en       = S_sel & S_wr;
  assign sel         = S_address[ADDR_W-1 -: SEL_W];
  assign clr_hit     = wr_en && (sel == SEL_OPCLEAR) && S_din[0];
  assign unused_addr = ^S_address[ADDR_W-SEL_W-1:0];
  assign busy        = (state == BUSY);

  // Priority: reset > clear > completion > ordinary writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      start_pulse  <= 1'b0;
      clear_pulse  <= 1'b0;
      interrupt    <= 1'b0;
      reg_opstart  <= '0;
      reg_opclear  <= '0;
      reg_opdone   <= '0;
      reg_intrEn   <= '0;
      reg_operand  <= '0;
      reg_result_h <= '0;
      reg_result_l <= '0;
    end else begin
      start_pulse <= 1'b0;
      clear_pulse <= 1'b0;
      reg_opclear <= '0;
      interrupt   <= reg_opdone[0] & reg_intrEn[0];

      if (clr_hit) begin
        // intrEn deliberately survives a clear
        state        <= IDLE;
        clear_pulse  <= 1'b1;
        reg_opclear  <= DATA_W'(1);
        reg_opstart  <= '0;
        reg_opdone   <= '0;
        reg_operand  <= '0;
        reg_result_h <= '0;
        reg_result_l <= '0;
      end else begin
        if ((state == BUSY) && core_done) begin
          state          <= IDLE;
          reg_result_h   <= core_result_h;
          reg_result_l   <= core_result_l;
          reg_opdone     <= DATA_W'(1);
          reg_opstart[0] <= 1'b0;
        end

        // opstart/operand writes only land while idle, so they never
        // collide with a completion on the same edge.
        if (wr_en) begin
          case (sel)
            SEL_OPSTART: begin
              if (state == IDLE) begin
                reg_opstart <= S_din;
                if (S_din[0]) begin
                  start_pulse <= 1'b1;
                  state       <= BUSY;
                end
              end
            end
            SEL_INTREN:  reg_intrEn <= S_din;
            SEL_OPERAND: begin
              if (state == IDLE) reg_operand <= S_din;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_factocore_reg_writer.sv
// Directed bench for factocore_reg_writer: a register-array reference model
// checked every cycle, plus literal spot checks on the main scenarios.
module tb_factocore_reg_writer;

  logic        clk;
  logic        reset;
  logic        S_sel;
  logic        S_wr;
  logic [7:0]  S_address;
  logic [63:0] S_din;
  logic        core_done;
  logic [63:0] core_result_h;
  logic [63:0] core_result_l;
  logic        start_pulse;
  logic        clear_pulse;
  logic        busy;
  logic        interrupt;
  logic [63:0] reg_opstart;
  logic [63:0] reg_opclear;
  logic [63:0] reg_opdone;
  logic [63:0] reg_intrEn;
  logic [63:0] reg_operand;
  logic [63:0] reg_result_h;
  logic [63:0] reg_result_l;

  factocore_reg_writer dut (
    .clk          (clk),
    .reset        (reset),
    .S_sel        (S_sel),
    .S_wr         (S_wr),
    .S_address    (S_address),
    .S_din        (S_din),
    .core_done    (core_done),
    .core_result_h(core_result_h),
    .core_result_l(core_result_l),
    .start_pulse  (start_pulse),
    .clear_pulse  (clear_pulse),
    .busy         (busy),
    .interrupt    (interrupt),
    .reg_opstart  (reg_opstart),
    .reg_opclear  (reg_opclear),
    .reg_opdone   (reg_opdone),
    .reg_intrEn   (reg_intrEn),
    .reg_operand  (reg_operand),
    .reg_result_h (reg_result_h),
    .reg_result_l (reg_result_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pulses_seen = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register file indexed by select code 0..6.
  logic [63:0] m_reg [7];
  logic        m_busy, m_start, m_clear, m_int;

  always @(posedge clk) begin
    logic       was_busy, old_done, old_ien, wr;
    logic [4:0] s;
    was_busy = m_busy;
    old_done = m_reg[2][0];
    old_ien  = m_reg[3][0];
    wr = S_sel & S_wr;
    s  = S_address[7:3];
    if (reset) begin
      for (int i = 0; i < 7; i++) m_reg[i] = '0;
      m_busy = 0; m_start = 0; m_clear = 0; m_int = 0;
    end else begin
      m_start = 0;
      m_clear = 0;
      m_reg[1] = '0;
      m_int = old_done & old_ien;
      if (wr && s == 5'd1 && S_din[0]) begin
        m_clear = 1;
        m_reg[1] = 64'd1;
        foreach (m_reg[i]) if (i != 1 && i != 3) m_reg[i] = '0;
        m_busy = 0;
      end else begin
        if (was_busy && core_done) begin
          m_reg[5] = core_result_h;
          m_reg[6] = core_result_l;
          m_reg[2] = 64'd1;
          m_reg[0][0] = 1'b0;
          m_busy = 0;
        end
        if (wr && s == 5'd0 && !was_busy) begin
          m_reg[0] = S_din;
          if (S_din[0]) begin m_start = 1; m_busy = 1; end
        end
        if (wr && s == 5'd3) m_reg[3] = S_din;
        if (wr && s == 5'd4 && !was_busy) m_reg[4] = S_din;
      end
    end
  end

  always @(negedge clk) begin
    if (start_pulse === 1'b1) pulses_seen++;
    if (check_en) begin
      chk("model start_pulse", 64'(start_pulse), 64'(m_start));
      chk("model clear_pulse", 64'(clear_pulse), 64'(m_clear));
      chk("model busy", 64'(busy), 64'(m_busy));
      chk("model interrupt", 64'(interrupt), 64'(m_int));
      chk("model opstart", reg_opstart, m_reg[0]);
      chk("model opclear", reg_opclear, m_reg[1]);
      chk("model opdone", reg_opdone, m_reg[2]);
      chk("model intrEn", reg_intrEn, m_reg[3]);
      chk("model operand", reg_operand, m_reg[4]);
      chk("model result_h", reg_result_h, m_reg[5]);
      chk("model result_l", reg_result_l, m_reg[6]);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_wr(input logic [7:0] addr, input logic [63:0] din);
    S_sel = 1; S_wr = 1; S_address = addr; S_din = din;
    tick();
    S_sel = 0; S_wr = 0; S_address = '0; S_din = '0;
  endtask

  task automatic complete(input logic [63:0] h, input logic [63:0] l);
    core_done = 1; core_result_h = h; core_result_l = l;
    tick();
    core_done = 0;
  endtask

  initial begin
    reset = 1; S_sel = 0; S_wr = 0; S_address = '0; S_din = '0;
    core_done = 0; core_result_h = '0; core_result_l = '0;
    tick(); tick();
    check_en = 1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset interrupt", 64'(interrupt), 64'd0);
    chk("reset opstart", reg_opstart, 64'd0);
    chk("reset result_l", reg_result_l, 64'd0);
    reset = 0;

    bus_wr(8'h18, 64'd1);
    chk("intrEn set", reg_intrEn, 64'd1);
    chk("intr idle", 64'(interrupt), 64'd0);

    bus_wr(8'h20, 64'd5);
    bus_wr(8'h00, 64'd1);
    chk("start pulse", 64'(start_pulse), 64'd1);
    chk("start busy", 64'(busy), 64'd1);
    tick();
    chk("pulse one cycle", 64'(start_pulse), 64'd0);

    bus_wr(8'h20, 64'd9);
    chk("lockout operand", reg_operand, 64'd5);
    bus_wr(8'h00, 64'd1);
    chk("lockout no pulse", 64'(start_pulse), 64'd0);

    complete(64'd0, 64'd120);
    chk("done result_l", reg_result_l, 64'd120);
    chk("done opdone", reg_opdone, 64'd1);
    chk("done busy", 64'(busy), 64'd0);
    chk("done opstart0", reg_opstart, 64'd0);
    chk("intr lag", 64'(interrupt), 64'd0);
    tick();
    chk("intr raised", 64'(interrupt), 64'd1);

    complete(64'd7, 64'd7);
    chk("idle done ignored", reg_result_l, 64'd120);

    bus_wr(8'h30, '1);
    bus_wr(8'h10, '1);
    bus_wr(8'h38, '1);
    bus_wr(8'h28, '1);
    chk("ro result_l", reg_result_l, 64'd120);
    chk("ro result_h", reg_result_h, 64'd0);
    chk("ro opdone", reg_opdone, 64'd1);

    bus_wr(8'h08, 64'd0);
    chk("clear din0=0", 64'(clear_pulse), 64'd0);

    bus_wr(8'h08, 64'd1);
    chk("clear pulse", 64'(clear_pulse), 64'd1);
    chk("clear reg", reg_opclear, 64'd1);
    chk("clear opdone", reg_opdone, 64'd0);
    chk("clear operand", reg_operand, 64'd0);
    chk("clear result", reg_result_l, 64'd0);
    chk("clear keeps ien", reg_intrEn, 64'd1);
    tick();
    chk("clear self-clr", reg_opclear, 64'd0);
    chk("intr fell", 64'(interrupt), 64'd0);

    // Clear on the same edge as completion: clear wins
    bus_wr(8'h20, 64'd3);
    bus_wr(8'h00, 64'd1);
    core_done = 1; core_result_h = 64'd5; core_result_l = 64'd6;
    bus_wr(8'h08, 64'd1);
    core_done = 0;
    chk("simul busy", 64'(busy), 64'd0);
    chk("simul opdone", reg_opdone, 64'd0);
    chk("simul result_l", reg_result_l, 64'd0);
    chk("simul result_h", reg_result_h, 64'd0);

    // Dropping intrEn lowers interrupt one cycle later
    bus_wr(8'h00, 64'd1);
    complete(64'hDEAD, 64'hBEEF);
    tick();
    chk("intr again", 64'(interrupt), 64'd1);
    bus_wr(8'h18, 64'd0);
    chk("intr lags ien", 64'(interrupt), 64'd1);
    tick();
    chk("intr off", 64'(interrupt), 64'd0);

    bus_wr(8'h00, 64'h10);
    chk("opstart no go", reg_opstart, 64'h10);
    chk("no go busy", 64'(busy), 64'd0);

    // Reset overrides an in-flight operation
    bus_wr(8'h00, 64'd1);
    reset = 1;
    tick();
    reset = 0;
    chk("reset busy mid", 64'(busy), 64'd0);
    chk("reset opdone", reg_opdone, 64'd0);
    tick();

    chk("start pulse count", 64'(pulses_seen), 64'd4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
